// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream handshake.
// Stage 0 registers bitwise generate/propagate; each later stage runs a slice
// of the prefix levels; the final stage forms sum/cout/ovf into output flops.
module ksa_pipe #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned L      = (WIDTH <= 1) ? 0 : $clog2(WIDTH);
  localparam int unsigned NSTAGE = (L == 0) ? 1 : (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int          LI     = int'(L);
  localparam int          NSI    = int'(NSTAGE);
  localparam int          LPSI   = int'(LEVELS_PER_STAGE);

  logic             en_c;
  logic [WIDTH-1:0] bx_c;
  logic             c0_c;

  // Stage registers 0..NSTAGE-1 hold group G/P, raw propagate and carry-in.
  logic [WIDTH-1:0] g_q    [NSTAGE];
  logic [WIDTH-1:0] p_q    [NSTAGE];
  logic [WIDTH-1:0] praw_q [NSTAGE];
  logic [NSTAGE-1:0] c0_q;
  logic [NSTAGE:0]   vld_q;

  // Prefix outputs of stages 1..NSTAGE.
  logic [WIDTH-1:0] g_c [1:NSTAGE];
  logic [WIDTH-1:0] p_c [1:NSTAGE];
  logic [WIDTH-1:0] gt_c;
  logic [WIDTH-1:0] pt_c;

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // Whole pipe advances together whenever the output slot is free or drained.
  assign en_c      = out_ready | ~out_valid;
  assign in_ready  = en_c;
  assign out_valid = vld_q[NSTAGE];

  // Subtraction as a + ~b + ~cin.
  assign bx_c = sub ? ~b : b;
  assign c0_c = sub ? ~cin : cin;

  // Kogge-Stone prefix levels, sliced LEVELS_PER_STAGE per stage (last takes the rest).
  always_comb begin
    gt_c = '0;
    pt_c = '0;
    for (int s = 1; s <= NSI; s++) begin
      g_c[s] = '0;
      p_c[s] = '0;
    end
    for (int s = 1; s <= NSI; s++) begin
      gt_c = g_q[s-1];
      pt_c = p_q[s-1];
      for (int lv = 0; lv < LI; lv++) begin
        if (lv >= (s - 1) * LPSI && lv < s * LPSI) begin
          gt_c = gt_c | (pt_c & (gt_c << (1 << lv)));
          pt_c = pt_c & ((pt_c << (1 << lv)) | ~({WIDTH{1'b1}} << (1 << lv)));
        end
      end
      g_c[s] = gt_c;
      p_c[s] = pt_c;
    end
  end

  // Carries into every bit from the full-span group terms and c0; then sum/cout/ovf.
  always_comb begin
    carry_c = {g_c[NSTAGE] | (p_c[NSTAGE] & {WIDTH{c0_q[NSTAGE-1]}}), c0_q[NSTAGE-1]};
    sum_d   = praw_q[NSTAGE-1] ^ carry_c[WIDTH-1:0];
    cout_d  = carry_c[WIDTH];
    ovf_d   = carry_c[WIDTH] ^ carry_c[WIDTH-1];
  end

  // Datapath stage registers; no reset needed as valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en_c) begin
      g_q[0]    <= a & bx_c;
      p_q[0]    <= a ^ bx_c;
      praw_q[0] <= a ^ bx_c;
      c0_q[0]   <= c0_c;
      for (int s = 1; s < NSI; s++) begin
        g_q[s]    <= g_c[s];
        p_q[s]    <= p_c[s];
        praw_q[s] <= praw_q[s-1];
        c0_q[s]   <= c0_q[s-1];
      end
    end
  end

  // Valid shift chain and result flops; results only load for real beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (en_c) begin
      vld_q <= {vld_q[NSTAGE-1:0], in_valid};
      if (vld_q[NSTAGE-1]) begin
        sum  <= sum_d;
        cout <= cout_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule
